// File: rtl/hex_scan_if.sv
// Load bus for hex_scan_driver: packed hex word, per-digit enable mask and capture strobe.
// load_i is a one-cycle strobe with no ready; the driver accepts every strobe, last write wins.
interface hex_scan_if #(
    parameter int DIGITS = 8
) ();
    logic [4*DIGITS-1:0] data_i;
    logic [DIGITS-1:0]   en_i;
    logic                load_i;

    modport master (output data_i, output en_i, output load_i);
    modport slave  (input  data_i, input  en_i, input  load_i);
endinterface

// File: rtl/hex_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-synchronous data update.
// Optional macro HEX_SCAN_LZ_BLANK_EN: blank leading-zero digits of the active value.
module hex_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    hex_scan_if.slave         bus,
    output logic [6:0]        hex,
    output logic [DIGITS-1:0] hex_on,
    output logic              frame_o
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]          presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [DIGITS-1:0]      pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic [DIGITS-1:0]      mask_q, mask_d, lz_mask;
    logic                   pend_valid_q, pend_valid_d;
    logic [6:0]             hex_q, hex_d;
    logic [DIGITS-1:0]      hex_on_q, hex_on_d;
    logic                   frame_q, frame_d;
    logic                   tick, boundary, past_blank, show;
    logic [3:0]             nibble;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0010000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    // Anodes stay off for the first BLANK_CYCLES of every slot to avoid ghosting.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (presc_q >= PW'(BLANK_CYCLES));
        end
    endgenerate

`ifdef HEX_SCAN_LZ_BLANK_EN
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen       = seen | (pend_data_q[4*k +: 4] != 4'h0);
            lz_mask[k] = seen | (k == 0);
        end
    end
`else
    assign lz_mask = '1;
`endif

    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);
    assign nibble   = act_data_q[{idx_q, 2'b00} +: 4];
    assign show     = act_en_q[idx_q] && mask_q[idx_q] && past_blank;

    always_comb begin
        presc_d      = tick ? '0 : presc_q + PW'(1);
        idx_d        = idx_q;
        pend_data_d  = pend_data_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        act_data_d   = act_data_q;
        act_en_d     = act_en_q;
        mask_d       = mask_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        if (boundary && pend_valid_q) begin
            act_data_d   = pend_data_q;
            act_en_d     = pend_en_q;
            mask_d       = lz_mask;
            pend_valid_d = 1'b0;
        end
        // A strobe coinciding with the boundary lands in pending for the next frame.
        if (bus.load_i) begin
            pend_data_d  = bus.data_i;
            pend_en_d    = bus.en_i;
            pend_valid_d = 1'b1;
        end
        hex_d    = show ? seg_decode(nibble) : 7'h7F;
        hex_on_d = show ? ~(DIGITS'(1) << idx_q) : '1;
        frame_d  = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            act_data_q   <= '0;
            act_en_q     <= '0;
            mask_q       <= '1;
            hex_q        <= 7'h7F;
            hex_on_q     <= '1;
            frame_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            act_data_q   <= act_data_d;
            act_en_q     <= act_en_d;
            mask_q       <= mask_d;
            hex_q        <= hex_d;
            hex_on_q     <= hex_on_d;
            frame_q      <= frame_d;
        end
    end

    assign hex     = hex_q;
    assign hex_on  = hex_on_q;
    assign frame_o = frame_q;
endmodule
